// File: rtl/niosii_debug_pkg.sv
// Shared definitions for the Nios II debug-slave OCI memory path:
// jdo field positions and the sequencer state encoding.
package niosii_debug_pkg;

    localparam int JDO_W        = 38;
    localparam int JDO_CLR_RDY  = 37;
    localparam int JDO_CLR_ERR  = 36;
    localparam int JDO_LD_ADDR  = 35;
    localparam int JDO_RD_NOW   = 34;
    localparam int JDO_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_WAIT = 2'd2
    } ocimem_state_t;

endpackage

// File: rtl/niosii_debug_ocimem_seq.sv
// Turns decoded JTAG debug-slave commands into single-word debug RAM accesses,
// owning the auto-incrementing monitor address and the ready/error status.
module niosii_debug_ocimem_seq
    import niosii_debug_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] MonAReg
);

    localparam int                CNT_W    = $clog2(RAM_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RAM_LAT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    ocimem_state_t     state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              ram_wr_q, ram_wr_d;
    logic              ram_rd_q, ram_rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              multi_strobe;
    logic              any_strobe;
    logic              acc_wr;
    logic              acc_rd;
    logic              drop;
    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W-1:0] jdo_addr;

    // jdo[33:32] carry nothing for either command type.
    logic unused_jdo;
    assign unused_jdo = ^jdo[33:32];

    assign jdo_addr     = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b)
                        | (take_action_ocimem_a & take_no_action_ocimem_a)
                        | (take_action_ocimem_b & take_no_action_ocimem_a);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        mon_a_d     = mon_a_q;
        mon_d_d     = mon_d_q;
        ready_d     = ready_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wr_d    = 1'b0;
        ram_rd_d    = 1'b0;
        cnt_d       = cnt_q;
        acc_wr      = 1'b0;
        acc_rd      = 1'b0;
        acc_addr    = mon_a_q;
        drop        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (multi_strobe) begin
                    drop = 1'b1;
                end else if (take_action_ocimem_a) begin
                    if (jdo[JDO_LD_ADDR]) mon_a_d = jdo_addr;
                    if (jdo[JDO_RD_NOW]) begin
                        acc_rd   = 1'b1;
                        acc_addr = jdo[JDO_LD_ADDR] ? jdo_addr : mon_a_q;
                    end
                end else if (take_action_ocimem_b) begin
                    acc_wr = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    acc_rd = 1'b1;
                end
            end
            ST_WR: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
                drop    = any_strobe;
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    mon_d_d = ram_rdata;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                drop = any_strobe;
            end
            default: state_d = ST_IDLE;
        endcase

        // An access needs the CPU parked in debug mode; otherwise it is dropped without moving MonAReg.
        if ((acc_wr || acc_rd) && !debugack) begin
            drop = 1'b1;
        end else if (acc_wr || acc_rd) begin
            ram_addr_d = acc_addr;
            mon_a_d    = acc_addr + ADDR_ONE;
            ready_d    = 1'b0;
            if (acc_wr) begin
                ram_wr_d    = 1'b1;
                ram_wdata_d = jdo[31:0];
                state_d     = ST_WR;
            end else begin
                ram_rd_d = 1'b1;
                cnt_d    = CNT_LOAD;
                state_d  = ST_RD_WAIT;
            end
        end

        if (take_action_ocimem_a && jdo[JDO_CLR_RDY]) ready_d = 1'b0;
        error_d = (error_q && !(take_action_ocimem_a && jdo[JDO_CLR_ERR])) || drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mon_a_q     <= '0;
            mon_d_q     <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wr_q    <= 1'b0;
            ram_rd_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            mon_a_q     <= mon_a_d;
            mon_d_q     <= mon_d_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wr_q    <= ram_wr_d;
            ram_rd_q    <= ram_rd_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_wdata     = ram_wdata_q;
    assign ram_wr        = ram_wr_q;
    assign ram_rd        = ram_rd_q;
    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign MonAReg       = mon_a_q;

endmodule

// File: tb/tb_niosii_debug_ocimem_seq.sv
// Self-checking bench for niosii_debug_ocimem_seq: command vector table plus
// hand sequences, with a RAM model and a scoreboard of expected RAM accesses.
module tb_niosii_debug_ocimem_seq;

    localparam int ADDR_W  = 8;
    localparam int RAM_LAT = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_a, take_b, take_na;
    logic              debugack;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_wr, ram_rd;
    logic [31:0]       ram_rdata;
    logic [31:0]       mon_d;
    logic              mon_ready, mon_error;
    logic [ADDR_W-1:0] mon_a;

    always #5 clk = ~clk;

    niosii_debug_ocimem_seq #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .debugack                (debugack),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_wr                  (ram_wr),
        .ram_rd                  (ram_rd),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (mon_d),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_error),
        .MonAReg                 (mon_a)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Debug RAM model: RAM_LAT=2 pipeline, data only valid in its window.
    logic [31:0] mem   [256];
    logic        wrote [256];
    logic [31:0] d1, d2;
    logic        v1 = 1'b0, v2 = 1'b0;
    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr]   <= ram_wdata;
            wrote[ram_addr] <= 1'b1;
        end
        d1 <= (wrote[ram_addr] === 1'b1) ? mem[ram_addr] : init_word(int'(ram_addr));
        v1 <= ram_rd;
        d2 <= d1;
        v2 <= v1;
    end
    assign ram_rdata = v2 ? d2 : 32'hBAD0_BAD0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } acc_t;
    acc_t        rd_q[$];
    acc_t        wr_q[$];
    logic [31:0] exp_mem [256];

    // Monitor: pops expected writes on ram_wr, expected reads on completion.
    bit rd_pending = 1'b0;
    int rd_wait    = 0;
    bit prev_ready = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rd_pending = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (ram_wr || ram_rd) check("wr_rd_exclusive", 64'(ram_wr & ram_rd), 64'(0));
                if (ram_wr) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_ram_wr_q_size", 64'(wr_q.size()), 64'(1));
                    end else begin
                        check("wr_addr", 64'(ram_addr), 64'(wr_q[0].addr));
                        check("wr_data", 64'(ram_wdata), 64'(wr_q[0].data));
                        void'(wr_q.pop_front());
                    end
                end
                if (ram_rd) begin
                    if (rd_q.size() == 0) begin
                        check("unexpected_ram_rd_q_size", 64'(rd_q.size()), 64'(1));
                    end else begin
                        check("rd_addr", 64'(ram_addr), 64'(rd_q[0].addr));
                        rd_pending = 1'b1;
                        rd_wait    = 0;
                    end
                end else if (rd_pending) begin
                    rd_wait++;
                end
                if (mon_ready && !prev_ready && rd_pending) begin
                    check("rd_latency", 64'(rd_wait), 64'(RAM_LAT + 1));
                    if (rd_q.size() != 0) begin
                        check("rd_data", 64'(mon_d), 64'(rd_q[0].data));
                        void'(rd_q.pop_front());
                    end
                    rd_pending = 1'b0;
                end
                prev_ready = mon_ready;
            end
        end
    end

    function automatic logic [37:0] cmd_a(input logic cr, input logic ce, input logic ld,
                                          input logic rn, input logic [7:0] addr);
        logic [37:0] j;
        j       = '0;
        j[37]   = cr;
        j[36]   = ce;
        j[35]   = ld;
        j[34]   = rn;
        j[9:2]  = addr;
        return j;
    endfunction

    function automatic logic [37:0] cmd_b(input logic [31:0] d);
        return {6'b0, d};
    endfunction

    typedef struct {
        logic        a, b, na, ack;
        logic [37:0] jdo;
        logic        ewr, erd;
        logic [7:0]  eaddr, emona;
        logic        eerr, erdy;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic b, input logic na, input logic ack,
                                input logic [37:0] j, input logic ewr, input logic erd,
                                input logic [7:0] eaddr, input logic [7:0] emona,
                                input logic eerr, input logic erdy);
        vec_t v;
        v.a = a; v.b = b; v.na = na; v.ack = ack; v.jdo = j;
        v.ewr = ewr; v.erd = erd; v.eaddr = eaddr; v.emona = emona;
        v.eerr = eerr; v.erdy = erdy;
        return v;
    endfunction

    // One-cycle strobe; returns at the negedge after the accepting edge.
    task automatic drive(input logic a, input logic b, input logic na, input logic ack,
                         input logic [37:0] j);
        @(negedge clk);
        take_a = a; take_b = b; take_na = na; debugack = ack; jdo = j;
        @(posedge clk);
        @(negedge clk);
        take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    endtask

    vec_t vec [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);

        vec[0]  = mk(1,0,0,1, cmd_a(0,0,1,0,8'h10),      0,0,8'h00,8'h10,0,0);
        vec[1]  = mk(0,1,0,1, cmd_b(32'hDEADBEEF),       1,0,8'h10,8'h11,0,1);
        vec[2]  = mk(1,0,0,1, cmd_a(0,0,1,1,8'h10),      0,1,8'h10,8'h11,0,1);
        vec[3]  = mk(0,1,0,1, cmd_b(32'h12345678),       1,0,8'h11,8'h12,0,1);
        vec[4]  = mk(1,0,0,1, cmd_a(0,0,1,0,8'hFF),      0,0,8'h00,8'hFF,0,1);
        vec[5]  = mk(0,0,1,1, 38'h0,                     0,1,8'hFF,8'h00,0,1);
        vec[6]  = mk(0,0,1,1, 38'h0,                     0,1,8'h00,8'h01,0,1);
        vec[7]  = mk(0,1,0,0, cmd_b(32'hCAFEF00D),       0,0,8'h00,8'h01,1,1);
        vec[8]  = mk(0,0,1,0, 38'h0,                     0,0,8'h00,8'h01,1,1);
        vec[9]  = mk(1,0,0,0, cmd_a(0,1,0,0,8'h00),      0,0,8'h00,8'h01,0,1);
        vec[10] = mk(1,0,0,1, cmd_a(1,0,0,0,8'h00),      0,0,8'h00,8'h01,0,0);
        vec[11] = mk(1,0,0,1, cmd_a(0,0,0,1,8'h77),      0,1,8'h01,8'h02,0,1);
        vec[12] = mk(1,0,0,1, cmd_a(1,0,1,1,8'h20),      0,1,8'h20,8'h21,0,1);

        reset_n = 1'b0; jdo = '0; debugack = 1'b1;
        take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ram_wr",   64'(ram_wr),    64'(0));
        check("rst_ram_rd",   64'(ram_rd),    64'(0));
        check("rst_MonAReg",  64'(mon_a),     64'(0));
        check("rst_MonDReg",  64'(mon_d),     64'(0));
        check("rst_ready",    64'(mon_ready), 64'(0));
        check("rst_error",    64'(mon_error), 64'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (vec[i].ewr) begin
                wr_q.push_back('{vec[i].eaddr, vec[i].jdo[31:0]});
                exp_mem[vec[i].eaddr] = vec[i].jdo[31:0];
            end
            if (vec[i].erd) rd_q.push_back('{vec[i].eaddr, exp_mem[vec[i].eaddr]});
            drive(vec[i].a, vec[i].b, vec[i].na, vec[i].ack, vec[i].jdo);
            check($sformatf("v%0d_ram_wr", i),  64'(ram_wr),    64'(vec[i].ewr));
            check($sformatf("v%0d_ram_rd", i),  64'(ram_rd),    64'(vec[i].erd));
            check($sformatf("v%0d_MonAReg", i), 64'(mon_a),     64'(vec[i].emona));
            check($sformatf("v%0d_error", i),   64'(mon_error), 64'(vec[i].eerr));
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_ready", i),   64'(mon_ready), 64'(vec[i].erdy));
            check($sformatf("v%0d_error_hold", i), 64'(mon_error), 64'(vec[i].eerr));
        end

        // Write strobe arriving while a read is in RD_WAIT is dropped.
        rd_q.push_back('{8'h21, exp_mem[8'h21]});
        @(negedge clk);
        take_na = 1'b1; debugack = 1'b1; jdo = '0;
        @(posedge clk);
        @(negedge clk);
        take_na = 1'b0; take_b = 1'b1; jdo = cmd_b(32'h5555AAAA);
        @(posedge clk);
        @(negedge clk);
        take_b = 1'b0;
        check("rdwait_b_error",   64'(mon_error), 64'(1));
        check("rdwait_b_no_wr",   64'(ram_wr),    64'(0));
        check("rdwait_b_MonAReg", 64'(mon_a),     64'(8'h22));
        repeat (5) @(negedge clk);
        check("rdwait_b_ready",   64'(mon_ready), 64'(1));
        check("rdwait_b_sticky",  64'(mon_error), 64'(1));
        drive(1, 0, 0, 1, cmd_a(0,1,0,0,8'h00));
        check("clr_err_1", 64'(mon_error), 64'(0));

        // Simultaneous A+B: both dropped, including the address load.
        drive(1, 1, 0, 1, cmd_a(0,0,1,1,8'h40));
        check("multi_no_wr",   64'(ram_wr),    64'(0));
        check("multi_no_rd",   64'(ram_rd),    64'(0));
        check("multi_MonAReg", 64'(mon_a),     64'(8'h22));
        check("multi_error",   64'(mon_error), 64'(1));
        repeat (3) @(negedge clk);
        check("multi_ready",   64'(mon_ready), 64'(1));
        drive(1, 0, 0, 1, cmd_a(0,1,0,0,8'h00));
        check("clr_err_2", 64'(mon_error), 64'(0));

        // Reset in RD_WAIT: read is abandoned, late RAM data never captured.
        rd_q.push_back('{8'h22, exp_mem[8'h22]});
        @(negedge clk);
        take_na = 1'b1;
        @(posedge clk);
        @(negedge clk);
        take_na = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_ram_rd",    64'(ram_rd),    64'(0));
        check("arst_ram_addr",  64'(ram_addr),  64'(0));
        check("arst_ram_wdata", 64'(ram_wdata), 64'(0));
        check("arst_MonAReg",   64'(mon_a),     64'(0));
        check("arst_MonDReg",   64'(mon_d),     64'(0));
        check("arst_ready",     64'(mon_ready), 64'(0));
        rd_q.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_MonDReg", 64'(mon_d),     64'(0));
        check("post_rst_ready",   64'(mon_ready), 64'(0));
        check("post_rst_MonAReg", 64'(mon_a),     64'(0));
        check("post_rst_error",   64'(mon_error), 64'(0));

        // RAM contents survive the sequencer reset.
        rd_q.push_back('{8'h11, exp_mem[8'h11]});
        drive(1, 0, 0, 1, cmd_a(0,0,1,1,8'h11));
        check("post_rst_rd_MonAReg", 64'(mon_a), 64'(8'h12));
        repeat (5) @(negedge clk);
        check("post_rst_rd_ready", 64'(mon_ready), 64'(1));

        check("rd_q_drained", 64'(rd_q.size()), 64'(0));
        check("wr_q_drained", 64'(wr_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
